// File: rtl/dm_access_ctrl.sv
// Load/store sequencer between the datapath and a word-only data memory.
// Optional macro DM_MISALIGN_EXC_EN: misaligned accesses end with err instead of being aligned.
module dm_access_ctrl #(
  parameter int unsigned ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req,
  input  logic [2:0]        op,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_din,
  input  logic [31:0]       dm_dout
);

  localparam int unsigned BaW = ADDR_W + 2;

  localparam logic [2:0] OpLw  = 3'd0;
  localparam logic [2:0] OpLh  = 3'd1;
  localparam logic [2:0] OpLhu = 3'd2;
  localparam logic [2:0] OpLb  = 3'd3;
  localparam logic [2:0] OpLbu = 3'd4;
  localparam logic [2:0] OpSw  = 3'd5;
  localparam logic [2:0] OpSh  = 3'd6;
  localparam logic [2:0] OpSb  = 3'd7;

  typedef enum logic [1:0] {StIdle, StAccess, StWrite, StDone} state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q;
  logic [BaW-1:0]   addr_q;
  logic [31:0]      wdata_q, buf_q, rdata_q;
  logic             accept, load_en, buf_en;
  logic             word_op, half_op, misalign;
  logic [BaW-1:0]   addr_in;
  logic [31:0]      load_val, merged;
  logic [7:0]       lane_b;
  logic [15:0]      lane_h;
  logic             unused_addr_hi;

  assign unused_addr_hi = ^addr[31:BaW];

  always_comb begin
    word_op  = (op == OpLw) || (op == OpSw);
    half_op  = (op == OpLh) || (op == OpLhu) || (op == OpSh);
    misalign = (word_op && (addr[1:0] != 2'b00)) || (half_op && addr[0]);
    addr_in  = addr[BaW-1:0];
`ifndef DM_MISALIGN_EXC_EN
    // Without the exception, drop the offending low bits and carry on.
    if (word_op) begin
      addr_in[1:0] = 2'b00;
    end else if (half_op) begin
      addr_in[0] = 1'b0;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    load_en = 1'b0;
    buf_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          accept  = 1'b1;
          state_d = StAccess;
`ifdef DM_MISALIGN_EXC_EN
          if (misalign) state_d = StDone;
`endif
        end
      end
      StAccess: begin
        if ((op_q == OpSh) || (op_q == OpSb)) begin
          buf_en  = 1'b1;
          state_d = StWrite;
        end else begin
          load_en = (op_q != OpSw);
          state_d = StDone;
        end
      end
      StWrite: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Lane extraction for loads and lane replacement for sub-word stores.
  always_comb begin
    lane_b = dm_dout[{addr_q[1:0], 3'b000} +: 8];
    lane_h = addr_q[1] ? dm_dout[31:16] : dm_dout[15:0];
    case (op_q)
      OpLh:    load_val = {{16{lane_h[15]}}, lane_h};
      OpLhu:   load_val = {16'h0000, lane_h};
      OpLb:    load_val = {{24{lane_b[7]}}, lane_b};
      OpLbu:   load_val = {24'h000000, lane_b};
      default: load_val = dm_dout;
    endcase
    merged = buf_q;
    if (op_q == OpSb) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  always_comb begin
    busy    = (state_q != StIdle);
    done    = (state_q == StDone);
    dm_addr = addr_q[BaW-1:2];
    dm_we   = 1'b0;
    dm_din  = 32'h0;
    if ((state_q == StAccess) && (op_q == OpSw)) begin
      dm_we  = 1'b1;
      dm_din = wdata_q;
    end else if (state_q == StWrite) begin
      dm_we  = 1'b1;
      dm_din = merged;
    end
  end

  assign rdata = rdata_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      op_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      buf_q   <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= op;
        addr_q  <= addr_in;
        wdata_q <= wdata;
      end
      if (buf_en)  buf_q   <= dm_dout;
      if (load_en) rdata_q <= load_val;
    end
  end

`ifdef DM_MISALIGN_EXC_EN
  logic err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= misalign;
    end
  end

  assign err = done && err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl with a 128 x 32 behavioural data memory.
module tb_dm_access_ctrl;

  logic        clk, rstn, req;
  logic [2:0]  op;
  logic [31:0] addr, wdata, rdata, dm_din, dm_dout;
  logic        busy, done, err, dm_we;
  logic [6:0]  dm_addr;

  logic [31:0] mem [128];
  logic        pl_we;
  logic [6:0]  pl_addr;
  logic [31:0] pl_din;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  int          r_lat, r_we;
  logic [6:0]  r_wa;
  logic [31:0] r_wd;
  logic        r_err;
  logic [31:0] saved;

  dm_access_ctrl #(.ADDR_W(7)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .req     (req),
    .op      (op),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .dm_we   (dm_we),
    .dm_addr (dm_addr),
    .dm_din  (dm_din),
    .dm_dout (dm_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dm_dout = mem[dm_addr];

  always @(posedge clk) begin
    if (dm_we) mem[dm_addr] <= dm_din;
    else if (pl_we) mem[pl_addr] <= pl_din;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [6:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = a; pl_din = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  // Issue one request; record latency, write count/address/data and err at done.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                       input bit spam);
    @(negedge clk);
    req = 1'b1; op = o; addr = a; wdata = d;
    r_lat = 0; r_we = 0; r_wa = '0; r_wd = '0; r_err = 1'b0;
    @(negedge clk);
    req = spam;
    for (int c = 1; c <= 10; c++) begin
      if (dm_we) begin
        r_we++;
        r_wa = dm_addr;
        r_wd = dm_din;
      end
      if (done) begin
        r_lat = c;
        r_err = err;
        break;
      end
      req = spam;
      @(negedge clk);
    end
    req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0; req = 1'b0; op = 3'd0; addr = 32'h0; wdata = 32'h0;
    pl_we = 1'b0; pl_addr = '0; pl_din = 32'h0;
    #12;
    check("rst_rdata", rdata, 32'h0);
    check("rst_flags", {28'h0, busy, done, err, dm_we}, 32'h0);
    check("rst_dm_addr", {25'h0, dm_addr}, 32'h0);
    check("rst_dm_din", dm_din, 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    // SW word store
    do_op(3'd5, 32'h10, 32'hDEADBEEF, 1'b0);
    check("sw_lat", r_lat, 2);
    check("sw_we_cnt", r_we, 1);
    check("sw_addr", {25'h0, r_wa}, 32'd4);
    check("sw_din", r_wd, 32'hDEADBEEF);
    check("sw_mem", mem[4], 32'hDEADBEEF);

    // Loads with lane select and extension
    preload(7'd4, 32'h80FF7F01);
    do_op(3'd3, 32'h13, 32'h0, 1'b0);
    check("lb_13", rdata, 32'hFFFFFF80);
    check("lb_lat", r_lat, 2);
    check("lb_we_cnt", r_we, 0);
    do_op(3'd4, 32'h13, 32'h0, 1'b0);
    check("lbu_13", rdata, 32'h00000080);
    do_op(3'd1, 32'h10, 32'h0, 1'b0);
    check("lh_10", rdata, 32'h00007F01);
    do_op(3'd1, 32'h12, 32'h0, 1'b0);
    check("lh_12", rdata, 32'hFFFF80FF);
    do_op(3'd2, 32'h12, 32'h0, 1'b0);
    check("lhu_12", rdata, 32'h000080FF);
    do_op(3'd3, 32'h11, 32'h0, 1'b0);
    check("lb_11", rdata, 32'h0000007F);
    do_op(3'd0, 32'h10, 32'h0, 1'b0);
    check("lw_10", rdata, 32'h80FF7F01);

    // Sub-word stores via read-modify-write
    preload(7'd4, 32'h11223344);
    do_op(3'd7, 32'h11, 32'hFFFFFFAA, 1'b0);
    check("sb_lat", r_lat, 3);
    check("sb_we_cnt", r_we, 1);
    check("sb_din", r_wd, 32'h1122AA44);
    check("sb_mem", mem[4], 32'h1122AA44);
    do_op(3'd6, 32'h12, 32'h12345566, 1'b0);
    check("sh_lat", r_lat, 3);
    check("sh_din", r_wd, 32'h5566AA44);
    check("sh_mem", mem[4], 32'h5566AA44);

    // Requests held high while busy must be dropped
    do_op(3'd7, 32'h13, 32'h00000077, 1'b1);
    check("spam_we_cnt", r_we, 1);
    check("spam_lat", r_lat, 3);
    check("spam_idle", {30'h0, busy, done}, 32'h0);
    check("spam_mem", mem[4], 32'h7766AA44);

    // Address wrap: 0x210 aliases word 4
    do_op(3'd0, 32'h210, 32'h0, 1'b0);
    check("wrap_lw", rdata, 32'h7766AA44);

    // Reset asserted while an SH is in WRITE
    @(negedge clk);
    req = 1'b1; op = 3'd6; addr = 32'h10; wdata = 32'h0000BEEF;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    check("rstmid_we_before", {31'h0, dm_we}, 32'h1);
    rstn = 1'b0;
    #1;
    check("rstmid_flags", {28'h0, busy, done, err, dm_we}, 32'h0);
    check("rstmid_din", dm_din, 32'h0);
    check("rstmid_addr", {25'h0, dm_addr}, 32'h0);
    check("rstmid_rdata", rdata, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    check("rstmid_mem", mem[4], 32'h7766AA44);
    do_op(3'd0, 32'h10, 32'h0, 1'b0);
    check("rstmid_lw", rdata, 32'h7766AA44);

    // Misaligned accesses
    do_op(3'd5, 32'h11, 32'h01020304, 1'b0);
`ifdef DM_MISALIGN_EXC_EN
    check("mis_sw_lat", r_lat, 1);
    check("mis_sw_we_cnt", r_we, 0);
    check("mis_sw_err", {31'h0, r_err}, 32'h1);
    check("mis_sw_mem", mem[4], 32'h7766AA44);
    do_op(3'd1, 32'h13, 32'h0, 1'b0);
    check("mis_lh_err", {31'h0, r_err}, 32'h1);
    check("mis_lh_rdata", rdata, 32'h7766AA44);
`else
    check("mis_sw_lat", r_lat, 2);
    check("mis_sw_we_cnt", r_we, 1);
    check("mis_sw_addr", {25'h0, r_wa}, 32'd4);
    check("mis_sw_err", {31'h0, r_err}, 32'h0);
    check("mis_sw_mem", mem[4], 32'h01020304);
    do_op(3'd1, 32'h13, 32'h0, 1'b0);
    check("mis_lh_err", {31'h0, r_err}, 32'h0);
    check("mis_lh_rdata", rdata, 32'h00000102);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
- Load/store sequencer between the multi-cycle datapath and the word-only data memory (128 x 32, combinational read, synchronous write on DMWr).
- Turns LW/LH/LHU/LB/LBU/SW/SH/SB requests into word reads and writes.
- Sub-word loads are lane-selected and extended. Sub-word stores use a read-modify-write sequence.
- Little-endian lanes: byte offset 0 = bits [7:0].

Parameters:
- ADDR_W, 7, word-address width driven to memory (7 = 128 words). Byte address uses bits [ADDR_W+1:0].

Ports:
- clk  in  1  clock, all state updates on posedge.
- rstn  in  1  asynchronous active-low reset.
- req  in  1  request strobe; sampled only in IDLE.
- op  in  3  0=LW 1=LH 2=LHU 3=LB 4=LBU 5=SW 6=SH 7=SB.
- addr  in  32  byte address; bits above ADDR_W+1 ignored.
- wdata  in  32  store data; low byte/half used for SB/SH.
- rdata  out  32  load result, extended per op; held until the next load completes.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse on completion.
- err  out  1  one-cycle pulse with done on misaligned access (see Optional Feature).
- dm_we  out  1  to memory DMWr.
- dm_addr  out  ADDR_W  to memory word address.
- dm_din  out  32  to memory write data.
- dm_dout  in  32  from memory read data.

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE.
  - rdata=0, busy=0, done=0, err=0, dm_we=0, dm_addr=0, dm_din=0.
  - Latched op/addr/wdata cleared.
  - Reset mid-sequence aborts it immediately. No write is issued after rstn deasserts.
- States: IDLE, ACCESS, WRITE, DONE.
- IDLE:
  - On req=1, latch op, addr, wdata and go to ACCESS.
  - req while busy is ignored, not queued.
- ACCESS:
  - dm_addr = latched addr[ADDR_W+1:2].
  - Loads: select lane from dm_dout and register it into rdata. Go to DONE.
  - SW: dm_we=1, dm_din=wdata. Go to DONE.
  - SH/SB: register dm_dout into a merge buffer, dm_we=0. Go to WRITE.
- WRITE:
  - dm_we=1, dm_din = buffer with the target lane replaced.
  - SB at offset k replaces bits [8k+7:8k] with wdata[7:0].
  - SH at offset 0/2 replaces [15:0]/[31:16] with wdata[15:0].
  - Go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. A req in this cycle is ignored.
- Latency from the req-accept edge:
  - Loads and SW: done in cycle 2.
  - SH and SB: done in cycle 3.
- Load extension:
  - LH/LB sign-extend from bit 15/7.
  - LHU/LBU zero-extend.
  - Half offset 0 selects [15:0], offset 2 selects [31:16].
- Write rules:
  - dm_we is asserted in exactly one cycle per store and never for loads.
  - dm_addr is stable through ACCESS and WRITE.
- Address wrap: byte addresses beyond the memory depth alias modulo 2^(ADDR_W+2). No error is raised.

Optional Feature:
- Macro: DM_MISALIGN_EXC_EN.
- Defined:
  - Misaligned access (LW/SW with addr[1:0]!=0; LH/LHU/SH with addr[0]=1) goes IDLE->DONE directly.
  - err=1 with done. No dm_we; rdata unchanged.
- Undefined:
  - err tied 0.
  - Offending low bits are forced to 0 (word/half aligned) and the access proceeds normally.

Test Plan:
- SW addr=0x10, wdata=0xDEADBEEF -> dm_we high exactly one cycle with dm_addr=4, dm_din=0xDEADBEEF; done in cycle 2.
- Mem[4]=0x80FF7F01: LB addr=0x13 -> rdata=0xFFFFFF80. LBU addr=0x13 -> 0x00000080. LH addr=0x10 -> 0x00007F01. LH addr=0x12 -> 0xFFFF80FF.
- Mem[4]=0x11223344: SB addr=0x11, wdata=0xAA -> write 0x1122AA44 in WRITE, done in cycle 3. Then SH addr=0x12, wdata=0x5566 -> 0x5566AA44.
- req pulses during ACCESS/WRITE/DONE of an SB -> exactly one write, one done pulse; extra reqs dropped.
- rstn low during WRITE of an SH -> outputs 0 immediately; memory word unchanged; next LW returns the original value.
- With DM_MISALIGN_EXC_EN, SW addr=0x11 -> done=err=1 in cycle 1, no dm_we. Without it -> write lands at dm_addr=4, err=0.
